// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS core types and constants: datapath width
//               defaults and the load-type encoding used by the MEM/WB path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Datapath defaults
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // Load-type encoding; codes 5..7 are treated as a full-word load
  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
// Module      : load_formatter
// Description : Combinational writeback formatter. Selects ALU result or
//               load data and, for sub-word loads, extracts the addressed
//               little-endian lane and sign/zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_formatter (
  input  logic                           i_mem_to_reg,
  input  logic [mips_pkg::DATA_WIDTH-1:0] i_alu_result,
  input  logic [mips_pkg::DATA_WIDTH-1:0] i_mem_rdata,
  input  logic [2:0]                     i_load_type,
  input  logic [1:0]                     i_byte_off,
  output logic [mips_pkg::DATA_WIDTH-1:0] o_data
);
  import mips_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword lanes; halfword ignores offset bit 0
  always_comb begin
    w_byte = i_mem_rdata[7:0];
    case (i_byte_off)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = i_byte_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  end

  // Choose the source and extend the selected lane according to load type
  always_comb begin
    o_data = i_mem_rdata;
    if (!i_mem_to_reg) begin
      o_data = i_alu_result;
    end else begin
      case (i_load_type)
        LT_LH:   o_data = {{16{w_half[15]}}, w_half};
        LT_LHU:  o_data = {16'h0000, w_half};
        LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
        LT_LBU:  o_data = {24'h000000, w_byte};
        default: o_data = i_mem_rdata;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register and writeback formatter. Registers
//               the formatted result and drives the register-file write port
//               one cycle later, with a forwarding tap and a retire counter.
//               Optional macro MEM_WB_FWD_EN enables the forwarding tap;
//               when undefined the fwd_* outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_reg_we,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_mem_to_reg,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_byte_off,
  output logic                  w_ena,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [31:0]           retired
);

  logic                  r_valid;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic [31:0]           r_retired;
  logic [DATA_WIDTH-1:0] w_fmt_data;

  load_formatter u_load_formatter (
    .i_mem_to_reg (in_mem_to_reg),
    .i_alu_result (in_alu_result),
    .i_mem_rdata  (in_mem_rdata),
    .i_load_type  (in_load_type),
    .i_byte_off   (in_byte_off),
    .o_data       (w_fmt_data)
  );

  // Pipeline register: reset clears, flush invalidates, stall holds, else capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (flush) begin
      // Only validity matters after a flush; the payload is left as-is
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_we    <= in_reg_we;
      r_rd    <= in_rd;
      r_data  <= w_fmt_data;
    end
  end

  // Retire counter: an instruction leaves the stage when it moves on unstalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_valid && !stall && !flush) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  // Writes to r0 are squashed here so downstream never sees them
  assign w_ena   = r_valid & r_we & (r_rd != '0);
  assign w_addr  = r_rd;
  assign w_data  = r_data;
  assign retired = r_retired;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = w_ena;
  assign fwd_addr  = w_addr;
  assign fwd_data  = w_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage: directed vector table,
//               hand-written stall/flush/reset sequences and randomized
//               stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, in_valid, in_reg_we, in_mem_to_reg;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_alu_result, in_mem_rdata;
  logic [2:0]    in_load_type;
  logic [1:0]    in_byte_off;
  logic          w_ena, fwd_valid;
  logic [AW-1:0] w_addr, fwd_addr;
  logic [DW-1:0] w_data, fwd_data;
  logic [31:0]   retired;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_we(in_reg_we), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata), .in_load_type(in_load_type),
    .in_byte_off(in_byte_off), .w_ena(w_ena), .w_addr(w_addr),
    .w_data(w_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .retired(retired)
  );

  // Small register file fed by the write port
  logic [31:0] rf [32];
  always @(posedge clk) if (w_ena) rf[w_addr] <= w_data;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: what the stage currently holds
  bit          m_valid, m_we, m_known;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_ret;

  // Reference load formatting with plain shifts and integer arithmetic
  function automatic logic [31:0] ref_fmt(input logic mtr, input logic [31:0] alu,
                                          input logic [31:0] rdata, input logic [2:0] lt,
                                          input logic [1:0] off);
    logic [31:0] sh;
    int v;
    if (!mtr) return alu;
    case (lt)
      3'd1, 3'd2: begin
        sh = rdata >> (16 * int'(off[1]));
        v  = int'(sh & 32'h0000FFFF);
        if (lt == 3'd1 && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      3'd3, 3'd4: begin
        sh = rdata >> (8 * int'(off));
        v  = int'(sh & 32'h000000FF);
        if (lt == 3'd3 && v >= 128) v = v - 256;
        return 32'(v);
      end
      default: return rdata;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic exp_ena;
    exp_ena = m_valid && m_we && (m_rd != 5'd0);
    chk({tag, " w_ena"}, 32'(w_ena), 32'(exp_ena));
    chk({tag, " retired"}, retired, m_ret);
    if (m_known) begin
      chk({tag, " w_addr"}, 32'(w_addr), 32'(m_rd));
      chk({tag, " w_data"}, w_data, m_data);
    end
`ifdef MEM_WB_FWD_EN
    chk({tag, " fwd_valid"}, 32'(fwd_valid), 32'(exp_ena));
    if (m_known) begin
      chk({tag, " fwd_addr"}, 32'(fwd_addr), 32'(m_rd));
      chk({tag, " fwd_data"}, fwd_data, m_data);
    end
`else
    chk({tag, " fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({tag, " fwd_addr"}, 32'(fwd_addr), 32'd0);
    chk({tag, " fwd_data"}, fwd_data, 32'd0);
`endif
  endtask

  // One clock: advance the model from the inputs seen at the edge, then check
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_we = 0; m_rd = '0; m_data = '0; m_ret = '0; m_known = 1;
    end else begin
      if (m_valid && !stall && !flush) m_ret = m_ret + 32'd1;
      if (flush) begin
        m_valid = 0;
        m_known = 0;
      end else if (!stall) begin
        m_valid = in_valid;
        m_we    = in_reg_we;
        m_rd    = in_rd;
        m_data  = ref_fmt(in_mem_to_reg, in_alu_result, in_mem_rdata, in_load_type, in_byte_off);
        m_known = 1;
      end
    end
    #1;
    chk_all(tag);
  endtask

  task automatic drive(input logic v, input logic we, input logic mtr, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [2:0] lt, input logic [1:0] off,
                       input logic [4:0] rd);
    in_valid = v; in_reg_we = we; in_mem_to_reg = mtr; in_alu_result = alu;
    in_mem_rdata = rdata; in_load_type = lt; in_byte_off = off; in_rd = rd;
  endtask

  typedef struct {
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [14];
  logic [31:0] ret0;

  initial begin
    vt[0]  = '{1'b1, 32'h0, 32'h8899AABB, LT_LB,  2'd1, 5'd3,  32'hFFFFFFAA};
    vt[1]  = '{1'b1, 32'h0, 32'h8899AABB, LT_LBU, 2'd3, 5'd4,  32'h00000088};
    vt[2]  = '{1'b1, 32'h0, 32'h80017FFF, LT_LH,  2'd2, 5'd5,  32'hFFFF8001};
    vt[3]  = '{1'b1, 32'h0, 32'h80017FFF, LT_LHU, 2'd0, 5'd6,  32'h00007FFF};
    vt[4]  = '{1'b1, 32'h0, 32'h80017FFF, LT_LH,  2'd1, 5'd7,  32'h00007FFF};
    vt[5]  = '{1'b1, 32'h0, 32'h12345678, LT_LW,  2'd2, 5'd8,  32'h12345678};
    vt[6]  = '{1'b1, 32'h0, 32'hCAFEF00D, 3'd6,   2'd3, 5'd9,  32'hCAFEF00D};
    vt[7]  = '{1'b0, 32'hDEADBEEF, 32'h11111111, LT_LB, 2'd0, 5'd1, 32'hDEADBEEF};
    vt[8]  = '{1'b0, 32'hDEADBEEF, 32'h11111111, LT_LB, 2'd0, 5'd0, 32'hDEADBEEF};
    vt[9]  = '{1'b1, 32'h0, 32'h8899AABB, LT_LB,  2'd0, 5'd10, 32'hFFFFFFBB};
    vt[10] = '{1'b1, 32'h0, 32'h8899AABB, LT_LBU, 2'd2, 5'd11, 32'h00000099};
    vt[11] = '{1'b1, 32'h0, 32'h8899AABB, LT_LH,  2'd3, 5'd12, 32'hFFFF8899};
    vt[12] = '{1'b1, 32'h0, 32'h8899AABB, LT_LHU, 2'd3, 5'd13, 32'h00008899};
    vt[13] = '{1'b1, 32'h0, 32'h00007F00, LT_LB,  2'd1, 5'd14, 32'h0000007F};

    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    // Reset
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 2'd0, 5'd0);
    step("reset0");
    step("reset1");
    chk("reset w_ena", 32'(w_ena), 32'd0);
    chk("reset retired", retired, 32'd0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b1, vt[i].mtr, vt[i].alu, vt[i].rdata, vt[i].lt, vt[i].off, vt[i].rd);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d data", i), w_data, vt[i].exp);
      chk($sformatf("vec%0d ena", i), 32'(w_ena), (vt[i].rd != 5'd0) ? 32'd1 : 32'd0);
      if (i == 8) chk("rf[1] readback", rf[1], 32'hDEADBEEF);
      if (i == 9) chk("rf[0] untouched", rf[0], 32'h0);
    end

    // Stall holds outputs and retire count; flush with stall clears w_ena
    drive(1'b1, 1'b1, 1'b0, 32'hCAFEBABE, 32'h0, LT_LW, 2'd0, 5'd2);
    step("cap");
    ret0 = m_ret;
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h00000000, 32'h0, LT_LW, 2'd0, 5'd7);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("stall%0d", k));
      chk("stall w_ena", 32'(w_ena), 32'd1);
      chk("stall w_addr", 32'(w_addr), 32'd2);
      chk("stall w_data", w_data, 32'hCAFEBABE);
      chk("stall retired", retired, ret0);
    end
    flush = 1'b1;
    step("flush+stall");
    chk("flush w_ena", 32'(w_ena), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Reset mid-operation drops a pending write
    drive(1'b1, 1'b1, 1'b0, 32'h55AA55AA, 32'h0, LT_LW, 2'd0, 5'd5);
    step("pre-rst");
    chk("pre-rst w_ena", 32'(w_ena), 32'd1);
    rst_n = 1'b0;
    step("mid-rst");
    chk("mid-rst w_ena", 32'(w_ena), 32'd0);
    chk("mid-rst w_addr", 32'(w_addr), 32'd0);
    chk("mid-rst w_data", w_data, 32'd0);
    chk("mid-rst retired", retired, 32'd0);
    rst_n = 1'b1;

    // Retire counts every instruction, including non-writing ones
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k[0], 1'b0, 32'(k), 32'h0, LT_LW, 2'd0, 5'(k));
      step($sformatf("ret%0d", k));
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, LT_LW, 2'd0, 5'd0);
    step("ret-bub0");
    step("ret-bub1");
    chk("retire count", retired, 32'd4);

    // Randomized stimulus against the model
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      drive(($urandom % 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(0, 31)));
      step($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
